// File: rtl/lcd1602_responder_if.sv
// Parallel HD44780-style LCD bus: the host (master) drives en/rs/rw/data_i,
// and the panel (slave) drives data_o back under data_oe during reads.
interface lcd1602_responder_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_i;
    logic [7:0] lcd_data_o;
    logic       lcd_data_oe;

    modport master (
        output lcd_en, lcd_rs, lcd_rw, lcd_data_i,
        input  lcd_data_o, lcd_data_oe
    );

    modport slave (
        input  lcd_en, lcd_rs, lcd_rw, lcd_data_i,
        output lcd_data_o, lcd_data_oe
    );
endinterface

// File: rtl/lcd1602_responder.sv
// LCD1602 panel-side responder: decodes the 8-bit HD44780 bus and keeps a
// 2x16 visible DDRAM that an on-chip scanner reads through rd_addr/rd_data.
module lcd1602_responder #(
    parameter int BUSY_CYC  = 2000,
    parameter int CLEAR_CYC = 76500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lcd1602_responder_if.slave    bus,
    input  logic [4:0]            rd_addr,
    output logic [7:0]            rd_data,
    output logic                  disp_on,
    output logic                  cursor_on,
    output logic                  blink_on,
    output logic [4:0]            cursor_idx,
    output logic                  cursor_vis,
    output logic                  busy,
    output logic                  err_flag
);

    localparam int MAX_CYC = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYC);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // Address counter step; the two visible-row windows wrap into each other.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == 7'h27)      nxt = 7'h40;
            else if (ac == 7'h67) nxt = 7'h00;
            else                  nxt = {ac[6], ac[5:0] + 6'd1};
        end else begin
            if (ac == 7'h00)      nxt = 7'h67;
            else if (ac == 7'h40) nxt = 7'h27;
            else                  nxt = {ac[6], ac[5:0] - 6'd1};
        end
        return nxt;
    endfunction

    function automatic logic ac_visible(input logic [6:0] ac);
        return (ac[5:4] == 2'b00);
    endfunction

    logic       en_s1_r, en_s2_r, en_prev_r;
    logic       rs_s1_r, rs_s2_r, rs_prev_r;
    logic       rw_s1_r, rw_s2_r, rw_prev_r;
    logic [7:0] data_s1_r, data_s2_r, data_prev_r;
    logic       fall_s;

    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [4:0]       sweep_idx_r, sweep_idx_n;
    logic [6:0]       ac_r, ac_n;
    logic             id_r, id_n, sh_r, sh_n;
    logic             d_r, d_n, c_r, c_n, b_r, b_n;
    logic             dl_r, dl_n, nl_r, nl_n, font_r, font_n;
    logic             err_r, err_n, busy_r;

    logic             wr_en_s;
    logic [4:0]       wr_addr_s;
    logic [7:0]       wr_data_s;
    logic [7:0]       ddram_r [32];
    logic [7:0]       rd_data_r, host_byte_s, data_o_r;
    logic             oe_r;

    // Two-flop synchronisers plus a one-cycle history for edge capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1_r <= 1'b0;  en_s2_r <= 1'b0;  en_prev_r <= 1'b0;
            rs_s1_r <= 1'b0;  rs_s2_r <= 1'b0;  rs_prev_r <= 1'b0;
            rw_s1_r <= 1'b0;  rw_s2_r <= 1'b0;  rw_prev_r <= 1'b0;
            data_s1_r <= 8'h00; data_s2_r <= 8'h00; data_prev_r <= 8'h00;
        end else begin
            en_s1_r <= bus.lcd_en;      en_s2_r <= en_s1_r;    en_prev_r <= en_s2_r;
            rs_s1_r <= bus.lcd_rs;      rs_s2_r <= rs_s1_r;    rs_prev_r <= rs_s2_r;
            rw_s1_r <= bus.lcd_rw;      rw_s2_r <= rw_s1_r;    rw_prev_r <= rw_s2_r;
            data_s1_r <= bus.lcd_data_i; data_s2_r <= data_s1_r; data_prev_r <= data_s2_r;
        end
    end

    assign fall_s = en_prev_r & ~en_s2_r;

    // Next-state: busy/sweep sequencing, then the bus transaction on an en fall
    always_comb begin
        state_n = state_r;  cnt_n = cnt_r;  sweep_idx_n = sweep_idx_r;
        ac_n = ac_r;  id_n = id_r;  sh_n = sh_r;
        d_n = d_r;  c_n = c_r;  b_n = b_r;
        dl_n = dl_r;  nl_n = nl_r;  font_n = font_r;
        err_n = err_r;
        wr_en_s = 1'b0;  wr_addr_s = 5'd0;  wr_data_s = 8'h00;

        case (state_r)
            ST_SWEEP: begin
                wr_en_s     = 1'b1;
                wr_addr_s   = sweep_idx_r;
                wr_data_s   = 8'h20;
                sweep_idx_n = sweep_idx_r + 5'd1;
                cnt_n       = cnt_r - CNT_ONE;
                if (sweep_idx_r == 5'd31) begin
                    state_n = (cnt_r <= CNT_ONE) ? ST_IDLE : ST_BUSY;
                end else begin
                    state_n = ST_SWEEP;
                end
            end
            ST_BUSY: begin
                cnt_n = cnt_r - CNT_ONE;
                if (cnt_r <= CNT_ONE) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_BUSY;
                end
            end
            ST_IDLE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (fall_s) begin
            if (rw_prev_r) begin
                // Reads bypass busy; a data read advances the cursor
                if (rs_prev_r) begin
                    ac_n = ac_step(ac_r, id_r);
                end else begin
                    ac_n = ac_r;
                end
            end else if (state_r != ST_IDLE) begin
                err_n = 1'b1;
            end else if (rs_prev_r) begin
                if (ac_visible(ac_r)) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = {ac_r[6], ac_r[3:0]};
                    wr_data_s = data_prev_r;
                end else begin
                    wr_en_s = 1'b0;
                end
                ac_n    = ac_step(ac_r, id_r);
                state_n = ST_BUSY;
                cnt_n   = BUSY_LOAD;
            end else begin
                state_n = ST_BUSY;
                cnt_n   = BUSY_LOAD;
                casez (data_prev_r)
                    8'b1???_????: ac_n = data_prev_r[6:0];
                    8'b01??_????: begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                        cnt_n   = cnt_r;
                    end
                    8'b001?_????: begin
                        dl_n = data_prev_r[4]; nl_n = data_prev_r[3]; font_n = data_prev_r[2];
                    end
                    8'b0001_????: begin
                        if (!data_prev_r[3]) begin
                            ac_n = ac_step(ac_r, data_prev_r[2]);
                        end else begin
                            ac_n = ac_r;
                        end
                    end
                    8'b0000_1???: begin
                        d_n = data_prev_r[2]; c_n = data_prev_r[1]; b_n = data_prev_r[0];
                    end
                    8'b0000_01??: begin
                        id_n = data_prev_r[1]; sh_n = data_prev_r[0];
                    end
                    8'b0000_001?: begin
                        ac_n  = 7'h00;
                        cnt_n = CLEAR_LOAD;
                    end
                    8'b0000_0001: begin
                        ac_n        = 7'h00;
                        id_n        = 1'b1;
                        state_n     = ST_SWEEP;
                        sweep_idx_n = 5'd0;
                        cnt_n       = CLEAR_LOAD;
                    end
                    default: cnt_n = BUSY_LOAD;
                endcase
            end
        end else begin
            err_n = err_r;
        end
    end

    // Control/status registers; reset launches the clear sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SWEEP;  cnt_r <= CLEAR_LOAD;  sweep_idx_r <= 5'd0;
            ac_r <= 7'h00;  id_r <= 1'b1;  sh_r <= 1'b0;
            d_r <= 1'b0;  c_r <= 1'b0;  b_r <= 1'b0;
            dl_r <= 1'b0;  nl_r <= 1'b0;  font_r <= 1'b0;
            err_r <= 1'b0;  busy_r <= 1'b1;
        end else begin
            state_r <= state_n;  cnt_r <= cnt_n;  sweep_idx_r <= sweep_idx_n;
            ac_r <= ac_n;  id_r <= id_n;  sh_r <= sh_n;
            d_r <= d_n;  c_r <= c_n;  b_r <= b_n;
            dl_r <= dl_n;  nl_r <= nl_n;  font_r <= font_n;
            err_r <= err_n;  busy_r <= (state_n != ST_IDLE);
        end
    end

    // DDRAM write port; contents are initialised by the reset sweep
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ddram_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Byte presented to the host on a data read
    always_comb begin
        host_byte_s = 8'h20;
        if (ac_visible(ac_r)) begin
            host_byte_s = ddram_r[{ac_r[6], ac_r[3:0]}];
        end else begin
            host_byte_s = 8'h20;
        end
    end

    // Registered scanner read and host read-back drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 8'h00;
            data_o_r  <= 8'h00;
            oe_r      <= 1'b0;
        end else begin
            rd_data_r <= ddram_r[rd_addr];
            if (en_s2_r && rw_s2_r) begin
                oe_r     <= 1'b1;
                data_o_r <= rs_s2_r ? host_byte_s : {busy_r, ac_r};
            end else begin
                oe_r     <= 1'b0;
                data_o_r <= 8'h00;
            end
        end
    end

    assign rd_data         = rd_data_r;
    assign bus.lcd_data_o  = data_o_r;
    assign bus.lcd_data_oe = oe_r;
    assign disp_on         = d_r;
    assign cursor_on       = c_r;
    assign blink_on        = b_r;
    assign cursor_idx      = {ac_r[6], ac_r[3:0]};
    assign cursor_vis      = ac_visible(ac_r);
    assign busy            = busy_r;
    assign err_flag        = err_r;

endmodule

// File: tb/tb_lcd1602_responder.sv
// Scoreboard bench for lcd1602_responder: host-side bus tasks drive the panel,
// expected bytes are queued at stimulus time and popped when the DUT answers.
module tb_lcd1602_responder;

    localparam int BUSY = 40;
    localparam int CLR  = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       disp_on, cursor_on, blink_on, cursor_vis, busy, err_flag;
    logic [4:0] cursor_idx;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_mem [32];
    logic [7:0] scan_q [$];
    logic [7:0] host_q [$];
    string      msg = "happy everyday !";

    lcd1602_responder_if bus ();

    lcd1602_responder #(.BUSY_CYC(BUSY), .CLEAR_CYC(CLR)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .disp_on    (disp_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .cursor_idx (cursor_idx),
        .cursor_vis (cursor_vis),
        .busy       (busy),
        .err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    // One en pulse with rs/rw/data held across it; returns after the commit
    task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data_i = d; bus.lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 4 * CLR) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b still set after %0d cycles", busy, k);
        end
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        pulse(rs, 1'b0, d);
        wait_idle();
    endtask

    // Host read cycle; the expected byte is queued before en is raised
    task automatic rd(input logic rs, input logic [7:0] expv, input string name);
        logic [7:0] e;
        host_q.push_back(expv);
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = 1'b1; bus.lcd_en = 1'b1;
        repeat (5) @(negedge clk);
        e = host_q.pop_front();
        n_tests++;
        if (bus.lcd_data_o !== e) begin
            n_fail++;
            $display("FAIL %s data: got %h expected %h", name, bus.lcd_data_o, e);
        end
        n_tests++;
        if (bus.lcd_data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL %s oe_high: got %b expected 1", name, bus.lcd_data_oe);
        end
        bus.lcd_en = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (bus.lcd_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s oe_low: got %b expected 0", name, bus.lcd_data_oe);
        end
        bus.lcd_rw = 1'b0;
    endtask

    // Pipelined scan of all 32 cells against the DDRAM model
    task automatic scan_all(input string name);
        logic [7:0] e;
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = scan_q.pop_front();
                n_tests++;
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL %s cell %0d: got %h expected %h", name, i - 1, rd_data, e);
                end
            end
            if (i < 32) begin
                rd_addr = 5'(i);
                scan_q.push_back(exp_mem[i]);
            end
        end
    endtask

    task automatic release_and_count(input string name);
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 4 * CLR);
        n_tests++;
        if (n !== CLR) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d cycles expected %0d", name, n, CLR);
        end
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({rd_data, bus.lcd_data_o, bus.lcd_data_oe} !== {8'h00, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%h o=%h oe=%b expected 00 00 0",
                     rd_data, bus.lcd_data_o, bus.lcd_data_oe);
        end
        n_tests++;
        if ({busy, err_flag, disp_on, cursor_on, blink_on, cursor_idx} !== {1'b1, 1'b0, 3'b000, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%b err=%b dcb=%b%b%b idx=%h expected 1 0 000 00",
                     busy, err_flag, disp_on, cursor_on, blink_on, cursor_idx);
        end
        release_and_count("reset");
        scan_all("reset_scan");
        rd(1'b0, 8'h00, "reset_status_read");
        n_tests++;
        if (err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", err_flag);
        end
    endtask

    task automatic test_sequence();
        wr(1'b0, 8'h38); wr(1'b0, 8'h08); wr(1'b0, 8'h01);
        wr(1'b0, 8'h06); wr(1'b0, 8'h0C); wr(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, msg[i]);
            exp_mem[i] = msg[i];
        end
        wr(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, 8'h41 + 8'(i));
            exp_mem[16 + i] = 8'h41 + 8'(i);
        end
        n_tests++;
        if ({disp_on, cursor_on, blink_on} !== 3'b100) begin
            n_fail++;
            $display("FAIL seq_dcb: got %b%b%b expected 100", disp_on, cursor_on, blink_on);
        end
        n_tests++;
        if ({cursor_idx, cursor_vis} !== {5'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL seq_cursor: got idx=%h vis=%b expected 10 0", cursor_idx, cursor_vis);
        end
        rd(1'b0, 8'h50, "seq_ac");
        scan_all("seq_scan");
    endtask

    task automatic test_boundary();
        wr(1'b0, 8'h8F); wr(1'b0, 8'h06);
        wr(1'b1, 8'h58);
        exp_mem[15] = 8'h58;
        n_tests++;
        if ({cursor_idx, cursor_vis} !== {5'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL bnd_invisible: got idx=%h vis=%b expected 00 0", cursor_idx, cursor_vis);
        end
        rd(1'b0, 8'h10, "bnd_ac10");
        for (int i = 0; i < 23; i++) wr(1'b1, 8'h60 + 8'(i));
        rd(1'b0, 8'h27, "bnd_ac27");
        wr(1'b1, 8'h77);
        rd(1'b0, 8'h40, "bnd_wrap40");
        n_tests++;
        if ({cursor_idx, cursor_vis} !== {5'h10, 1'b1}) begin
            n_fail++;
            $display("FAIL bnd_row1: got idx=%h vis=%b expected 10 1", cursor_idx, cursor_vis);
        end
        wr(1'b0, 8'h80); wr(1'b0, 8'h04);
        wr(1'b1, 8'h31);
        exp_mem[0] = 8'h31;
        rd(1'b0, 8'h67, "bnd_dec_wrap");
        scan_all("bnd_scan");
    endtask

    task automatic test_back_to_back();
        wr(1'b0, 8'h06); wr(1'b0, 8'h85);
        n_tests++;
        if (err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err_before: got %b expected 0", err_flag);
        end
        @(negedge clk);
        bus.lcd_rs = 1'b1; bus.lcd_rw = 1'b0; bus.lcd_data_i = 8'h77; bus.lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_en = 1'b0;
        repeat (6) @(negedge clk);
        bus.lcd_data_i = 8'h66; bus.lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_en = 1'b0;
        repeat (4) @(negedge clk);
        exp_mem[5] = 8'h77;
        n_tests++;
        if (err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_err_set: got %b expected 1", err_flag);
        end
        wait_idle();
        rd(1'b0, 8'h06, "b2b_ac");
        scan_all("b2b_scan");
        wr(1'b0, 8'h0C);
        n_tests++;
        if (err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_err_sticky: got %b expected 1", err_flag);
        end
    endtask

    task automatic test_read();
        pulse(1'b0, 1'b0, 8'h8A);
        rd(1'b0, 8'h8A, "read_busy_status");
        wait_idle();
        rd(1'b1, exp_mem[10], "read_ddram");
        rd(1'b0, 8'h0B, "read_ac_step");
    endtask

    task automatic test_reset_mid_sweep();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        release_and_count("midrst");
        scan_all("midrst_scan");
        n_tests++;
        if (err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_err: got %b expected 0", err_flag);
        end
    endtask

    task automatic test_bad_cmd();
        wr(1'b0, 8'h83);
        wr(1'b1, 8'h55);
        exp_mem[3] = 8'h55;
        n_tests++;
        if (err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_err_before: got %b expected 0", err_flag);
        end
        pulse(1'b0, 1'b0, 8'h40);
        wait_idle();
        n_tests++;
        if (err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_err_set: got %b expected 1", err_flag);
        end
        rd(1'b0, 8'h04, "bad_ac");
        scan_all("bad_scan");
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = 5'd0;
        bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data_i = 8'h00;
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        test_reset();
        test_sequence();
        test_boundary();
        test_back_to_back();
        test_read();
        test_reset_mid_sweep();
        test_bad_cmd();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd1602_responder.md
Name: lcd1602_responder

Overview:
- HD44780-compatible LCD1602 responder: the panel-side end of the 8-bit parallel LCD bus our LCD1602 drivers generate.
- Samples lcd_en/lcd_rs/lcd_rw/lcd_data, executes the instruction subset, and stores characters in a 32-byte visible DDRAM (2 rows x 16).
- Exposes the DDRAM through a read port for an on-chip display scanner (VGA/UART mirror) and serves as a bus-functional target in driver benches.

Parameters:
- BUSY_CYC, 2000, clk cycles busy after any write or instruction except clear/home (40 us at 50 MHz).
- CLEAR_CYC, 76500, clk cycles busy after clear or return-home (1.53 ms); must be >= 32.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- lcd_en  in  1  bus enable; writes commit on its falling edge
- lcd_rs  in  1  0 = instruction/status, 1 = data
- lcd_rw  in  1  0 = write, 1 = read
- lcd_data_i  in  8  bus data from host
- lcd_data_o  out  8  read data to host
- lcd_data_oe  out  1  drive enable for lcd_data_o
- rd_addr  in  5  scanner index: {row, col[3:0]}
- rd_data  out  8  DDRAM byte at rd_addr, 1-cycle latency
- disp_on, cursor_on, blink_on  out  1 each  display-control bits D/C/B
- cursor_idx  out  5  {ac[6], ac[3:0]}
- cursor_vis  out  1  ac points at a visible cell (low 6 bits <= 0x0F)
- busy  out  1  busy flag
- err_flag  out  1  sticky; a command arrived while busy, or an unsupported command (CGRAM address set) was received

Behaviour:
- Synchronisation: all bus inputs pass through 2-flop synchronisers. A falling edge is detected on synchronised en (previous 1, current 0). rs/rw/data are taken from the synchronised values of the cycle before the edge.
- Reset:
  - ac=0x00, I/D=1, S=0, D=C=B=0, DL/N/F=0, err_flag=0.
  - rd_data=0x00, lcd_data_o=0x00, lcd_data_oe=0.
  - A clear sweep starts immediately: busy=1 for CLEAR_CYC cycles; DDRAM is written 0x20 at one entry per cycle, indexes 0..31.
- Write instruction (rw=0, rs=0), decoded by highest set bit:
  - 0x01 clear: clear sweep, ac=0x00, I/D=1; busy for CLEAR_CYC.
  - 0x02/0x03 home: ac=0x00, DDRAM untouched; busy for CLEAR_CYC.
  - 0x04-0x07: I/D=data[1], S=data[0]. S is stored but display shift is not implemented.
  - 0x08-0x0F: D=data[2], C=data[1], B=data[0].
  - 0x10-0x1F: if data[3]=0, move cursor (data[2]=1 right / 0 left) using the AC step rule; if data[3]=1, no-op.
  - 0x20-0x3F: store DL=data[4], N=data[3], F=data[2]. Only 8-bit behaviour is implemented.
  - 0x40-0x7F: ignored; set err_flag.
  - 0x80-0xFF: ac=data[6:0].
- Write data (rw=0, rs=1):
  - If ac is visible, store data at {ac[6], ac[3:0]}; if not visible, the byte is discarded.
  - Then step ac per I/D.
- AC step rule:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
  - Otherwise +/-1 with bit 6 preserved.
  - Any ac value outside 0x00-0x27 and 0x40-0x67 written by set-address is stored as given; the next step follows +/-1 on the low 6 bits.
- Busy:
  - Any committed write loads the busy counter (BUSY_CYC or CLEAR_CYC); busy=1 until it expires.
  - A write edge while busy=1 is ignored entirely and sets err_flag.
  - A clear issued while idle always completes the sweep before busy drops.
- Read (rw=1):
  - lcd_data_oe=1 while synchronised en=1 and rw=1.
  - rs=0: lcd_data_o={busy, ac}.
  - rs=1: lcd_data_o=DDRAM[{ac[6], ac[3:0]}], or 0x20 if not visible; ac steps on the en falling edge.
  - Reads are never blocked by busy and never set err_flag.
- Scanner port: registered read. A same-cycle write to the same index returns the old byte; the new byte appears on the following read.
- Reset mid-operation (mid-sweep or mid-busy) aborts and restarts the reset sweep.

Test Plan:
- Reset, then wait CLEAR_CYC -> busy falls at cycle CLEAR_CYC; rd_data=0x20 for all 32 indexes; err_flag=0.
- Host writes 38,08,01,06,0C,80, "happy everyday !", C0, 16 bytes 0x41..0x50, spaced > CLEAR_CYC apart. Required response:
  - rd_addr 0..15 returns "happy everyday !".
  - rd_addr 16..31 returns 0x41..0x50.
  - disp_on=1, cursor_on=0.
  - ac=0x50.
- Boundary stepping:
  - Set ac=0x0F, I/D=1, write 0x58 -> stored at index 15; ac=0x10; cursor_vis=0.
  - Write 24 more bytes -> none stored; ac=0x28 wraps to 0x40 at the 24th byte.
  - Set ac=0x00, I/D=0, write 0x31 -> index 0 = 0x31; ac=0x67.
- Second write edge 10 cycles after the first (busy=1) -> DDRAM and ac unchanged by it; err_flag=1 and stays set.
- Read cycle rw=1, rs=0 during busy after 0x8A -> lcd_data_o=0x8A, oe high only while en high. Read with rs=1 at ac=0x0A -> returns the stored byte; ac=0x0B.
- Send instruction 0x40 -> err_flag=1; ac and DDRAM unchanged. Assert rst_n mid-sweep -> sweep restarts; all cells end at 0x20.
